// File: rtl/dram_write_serializer.sv
// Write-path serializer: buffers 64-bit write words and emits them as per-cycle
// rise/fall byte pairs with a DQS preamble/data/postamble envelope and data mask.
module dram_write_serializer #(
   parameter int FIFO_DEPTH      = 4,
   parameter int PREAMBLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_size,
   input  logic [2:0]  cmd_len,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [63:0] wr_data,
   output logic        dq_oe,
   output logic [7:0]  dq_rise,
   output logic [7:0]  dq_fall,
   output logic        dm_rise,
   output logic        dm_fall,
   output logic        dqs_oe,
   output logic        dqs_rise,
   output logic        dqs_fall,
   output logic        busy,
   output logic        done,
   output logic        underrun
);
   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] LP_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [1:0]  LP_PRE  = 2'(PREAMBLE_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_POST} state_t;

   state_t        r_state;
   logic [63:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;

   logic [1:0]    r_size;
   logic [2:0]    r_len;
   logic [2:0]    r_xfer;
   logic [1:0]    r_beat;
   logic [1:0]    r_pre_cnt;
   logic [63:0]   r_word;
   logic          r_xfer_masked;

   logic          r_dq_oe;
   logic [7:0]    r_dq_rise;
   logic [7:0]    r_dq_fall;
   logic          r_dm_rise;
   logic          r_dm_fall;
   logic          r_dqs_oe;
   logic          r_dqs_rise;
   logic          r_done;
   logic          r_underrun;

   logic          w_push;
   logic          w_pop;
   logic          w_empty;
   logic [63:0]   w_head;
   logic [1:0]    w_last_beat;
   logic          w_beat_last;
   logic          w_xfer_last;
   logic          w_pre_ok;
   logic          w_xfer_start;
   logic [63:0]   w_src_word;
   logic [1:0]    w_src_beat;
   logic          w_src_mask;
   logic [15:0]   w_beat_bytes;
   logic [7:0]    w_nx_rise;
   logic [7:0]    w_nx_fall;
   logic          w_nx_dm_rise;
   logic          w_nx_dm_fall;

   assign wr_ready  = (r_count != LP_FULL);
   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign dq_oe     = r_dq_oe;
   assign dq_rise   = r_dq_rise;
   assign dq_fall   = r_dq_fall;
   assign dm_rise   = r_dm_rise;
   assign dm_fall   = r_dm_fall;
   assign dqs_oe    = r_dqs_oe;
   assign dqs_rise  = r_dqs_rise;
   assign dqs_fall  = 1'b0;
   assign done      = r_done;
   assign underrun  = r_underrun;

   assign w_push  = wr_valid && wr_ready;
   assign w_empty = (r_count == '0);
   assign w_head  = r_mem[r_rptr];

   always_comb begin
      case (r_size)
         2'b10:   w_last_beat = 2'd1;
         2'b11:   w_last_beat = 2'd3;
         default: w_last_beat = 2'd0;
      endcase
   end

   assign w_beat_last = (r_beat == w_last_beat);
   assign w_xfer_last = (r_xfer == r_len);
   assign w_pre_ok    = (r_pre_cnt >= LP_PRE);

   // A transfer consumes its word when its first beat is registered.
   assign w_pop = !w_empty && (((r_state == S_PRE) && w_pre_ok) ||
                               ((r_state == S_DATA) && w_beat_last && !w_xfer_last));

   assign w_xfer_start = (r_state == S_PRE) || w_beat_last;
   assign w_src_word   = w_xfer_start ? w_head : r_word;
   assign w_src_beat   = w_xfer_start ? 2'd0 : r_beat + 2'd1;
   assign w_src_mask   = w_xfer_start ? w_empty : r_xfer_masked;

   always_comb begin
      case (w_src_beat)
         2'd1:    w_beat_bytes = w_src_word[31:16];
         2'd2:    w_beat_bytes = w_src_word[47:32];
         2'd3:    w_beat_bytes = w_src_word[63:48];
         default: w_beat_bytes = w_src_word[15:0];
      endcase
      w_nx_rise    = w_beat_bytes[7:0];
      w_nx_fall    = w_beat_bytes[15:8];
      w_nx_dm_rise = 1'b0;
      w_nx_dm_fall = 1'b0;
      if (w_src_mask) begin
         w_nx_rise    = 8'h00;
         w_nx_fall    = 8'h00;
         w_nx_dm_rise = 1'b1;
         w_nx_dm_fall = 1'b1;
      end else if (r_size == 2'b00) begin
         w_nx_fall    = 8'h00;
         w_nx_dm_fall = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_size        <= 2'b00;
         r_len         <= 3'd0;
         r_xfer        <= 3'd0;
         r_beat        <= 2'd0;
         r_pre_cnt     <= 2'd0;
         r_word        <= 64'd0;
         r_xfer_masked <= 1'b0;
         r_dq_oe       <= 1'b0;
         r_dq_rise     <= 8'h00;
         r_dq_fall     <= 8'h00;
         r_dm_rise     <= 1'b0;
         r_dm_fall     <= 1'b0;
         r_dqs_oe      <= 1'b0;
         r_dqs_rise    <= 1'b0;
         r_done        <= 1'b0;
         r_underrun    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_state   <= S_PRE;
                  r_size    <= cmd_size;
                  r_len     <= cmd_len;
                  r_xfer    <= 3'd0;
                  r_beat    <= 2'd0;
                  r_pre_cnt <= 2'd1;
                  r_dqs_oe  <= 1'b1;
               end
            end
            S_PRE: begin
               // Preamble runs its minimum length, then waits for the first word.
               if (w_pre_ok && !w_empty) begin
                  r_state       <= S_DATA;
                  r_word        <= w_head;
                  r_xfer_masked <= 1'b0;
                  r_beat        <= 2'd0;
                  r_dq_oe       <= 1'b1;
                  r_dqs_rise    <= 1'b1;
                  r_dq_rise     <= w_nx_rise;
                  r_dq_fall     <= w_nx_fall;
                  r_dm_rise     <= w_nx_dm_rise;
                  r_dm_fall     <= w_nx_dm_fall;
               end else if (!w_pre_ok) begin
                  r_pre_cnt <= r_pre_cnt + 2'd1;
               end
            end
            S_DATA: begin
               if (w_beat_last && w_xfer_last) begin
                  r_state    <= S_POST;
                  r_dq_oe    <= 1'b0;
                  r_dqs_rise <= 1'b0;
                  r_dq_rise  <= 8'h00;
                  r_dq_fall  <= 8'h00;
                  r_dm_rise  <= 1'b0;
                  r_dm_fall  <= 1'b0;
                  r_done     <= 1'b1;
               end else begin
                  r_dq_rise <= w_nx_rise;
                  r_dq_fall <= w_nx_fall;
                  r_dm_rise <= w_nx_dm_rise;
                  r_dm_fall <= w_nx_dm_fall;
                  if (w_beat_last) begin
                     // An empty FIFO here becomes a masked transfer; timing never stalls.
                     r_xfer        <= r_xfer + 3'd1;
                     r_beat        <= 2'd0;
                     r_word        <= w_head;
                     r_xfer_masked <= w_empty;
                     if (w_empty) r_underrun <= 1'b1;
                  end else begin
                     r_beat <= r_beat + 2'd1;
                  end
               end
            end
            S_POST: begin
               r_state  <= S_IDLE;
               r_dqs_oe <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dram_write_serializer.sv
// Scoreboard bench for dram_write_serializer: expected beats are queued per command
// and compared by a negedge monitor whenever the DUT drives DQ.
module tb_dram_write_serializer;
   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_size;
   logic [2:0]  cmd_len;
   logic        wr_valid;
   logic        wr_ready;
   logic [63:0] wr_data;
   logic        dq_oe;
   logic [7:0]  dq_rise;
   logic [7:0]  dq_fall;
   logic        dm_rise;
   logic        dm_fall;
   logic        dqs_oe;
   logic        dqs_rise;
   logic        dqs_fall;
   logic        busy;
   logic        done;
   logic        underrun;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [17:0] exp_q [$];
   logic [17:0] mon_beat;
   logic [63:0] words [4];

   dram_write_serializer #(.FIFO_DEPTH(4), .PREAMBLE_CYCLES(1)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_size(cmd_size), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .dq_oe(dq_oe), .dq_rise(dq_rise), .dq_fall(dq_fall),
      .dm_rise(dm_rise), .dm_fall(dm_fall),
      .dqs_oe(dqs_oe), .dqs_rise(dqs_rise), .dqs_fall(dqs_fall),
      .busy(busy), .done(done), .underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference beats for one transfer: {rise, fall, dm_rise, dm_fall}.
   task automatic expect_xfer(input logic [63:0] w, input int size, input bit masked);
      int cpt;
      cpt = (size == 3) ? 4 : (size == 2) ? 2 : 1;
      for (int k = 0; k < cpt; k++) begin
         if (masked)         exp_q.push_back({8'h00, 8'h00, 1'b1, 1'b1});
         else if (size == 0) exp_q.push_back({w[7:0], 8'h00, 1'b0, 1'b1});
         else                exp_q.push_back({w[16*k +: 8], w[16*k+8 +: 8], 1'b0, 1'b0});
      end
   endtask

   always @(negedge clk) begin
      if (!rst && dq_oe) begin
         check_eq("beat_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            mon_beat = exp_q.pop_front();
            check_eq("dq_rise", 64'(dq_rise), 64'(mon_beat[17:10]));
            check_eq("dq_fall", 64'(dq_fall), 64'(mon_beat[9:2]));
            check_eq("dm", 64'({dm_rise, dm_fall}), 64'(mon_beat[1:0]));
            check_eq("dqs_data", 64'({dqs_oe, dqs_rise, dqs_fall}), 64'b110);
            $display("beat rise=%02h fall=%02h dm=%b%b", dq_rise, dq_fall, dm_rise, dm_fall);
         end
      end
   end

   task automatic push_word(input logic [63:0] w);
      wr_valid = 1'b1;
      wr_data  = w;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic send_cmd(input logic [1:0] size, input logic [2:0] len);
      check_eq("cmd_ready_idle", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1;
      cmd_size  = size;
      cmd_len   = len;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check_eq("busy_after_acc", 64'({busy, cmd_ready}), 64'b10);
      $display("cmd size=%0d len=%0d accepted", size, len);
   endtask

   task automatic wait_done(input int exp_cycles);
      int c;
      c = 0;
      do begin
         @(negedge clk);
         c++;
         if (c == 1) check_eq("pre_state", 64'({dqs_oe, dqs_rise, dqs_fall, dq_oe}), 64'b1000);
      end while (!done && c < 200);
      check_eq("done_cycles", 64'(c), 64'(exp_cycles));
      check_eq("post_state", 64'({dqs_oe, dqs_rise, dq_oe, dm_rise, dm_fall}), 64'b10000);
      @(negedge clk);
      check_eq("idle_after", 64'({done, busy, dqs_oe, dq_oe, cmd_ready}), 64'b00001);
      $display("burst done after %0d cycles", c);
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_size = 2'b00; cmd_len = 3'd0;
      wr_valid = 1'b0; wr_data = 64'd0;
      repeat (2) @(negedge clk);
      check_eq("rst_enables", 64'({dq_oe, dqs_oe, dqs_rise, dm_rise, dm_fall, busy, done, underrun}), 64'd0);
      check_eq("rst_readies", 64'({wr_ready, cmd_ready}), 64'b11);
      rst = 1'b0;
      @(negedge clk);
      check_eq("idle_state", 64'({wr_ready, cmd_ready, dq_oe, dqs_oe, underrun}), 64'b11000);

      // Single transfers of each size, FIFO preloaded.
      words[0] = 64'h5a;
      words[1] = 64'he4f9;
      words[2] = 64'h485f8108;
      words[3] = 64'h44a874a4de89076b;
      for (int i = 0; i < 4; i++) push_word(words[i]);
      for (int s = 0; s < 4; s++) begin
         expect_xfer(words[s], s, 1'b0);
         send_cmd(2'(s), 3'd0);
         wait_done(1 + ((s == 3) ? 4 : (s == 2) ? 2 : 1) + 1);
      end

      // Back-to-back size-01 burst.
      words[0] = 64'he40b; words[1] = 64'hfc0d; words[2] = 64'h5d22; words[3] = 64'hc806;
      for (int i = 0; i < 4; i++) begin
         push_word(words[i]);
         expect_xfer(words[i], 1, 1'b0);
      end
      send_cmd(2'b01, 3'd3);
      wait_done(6);

      // Late data: preamble stretches until the first push lands.
      expect_xfer(64'h0aa01e5d, 2, 1'b0);
      expect_xfer(64'ha734ac38, 2, 1'b0);
      fork
         begin
            send_cmd(2'b10, 3'd1);
            wait_done(9);
         end
         begin
            repeat (3) @(negedge clk);
            push_word(64'h0aa01e5d);
            push_word(64'ha734ac38);
         end
      join
      check_eq("no_underrun", 64'(underrun), 64'd0);

      // Underrun on the second transfer.
      push_word(64'h0123456789abcdef);
      expect_xfer(64'h0123456789abcdef, 3, 1'b0);
      expect_xfer(64'd0, 3, 1'b1);
      send_cmd(2'b11, 3'd1);
      wait_done(10);
      check_eq("underrun_set", 64'(underrun), 64'd1);
      repeat (3) @(negedge clk);
      check_eq("underrun_sticky", 64'(underrun), 64'd1);

      // Backpressure, then reset in the 10th DATA cycle.
      for (int i = 0; i < 5; i++) begin
         check_eq("wr_ready_fill", 64'(wr_ready), 64'(i < 4));
         push_word(64'h1111_2222_3333_4444 * (i + 1));
      end
      check_eq("wr_ready_full", 64'(wr_ready), 64'd0);
      for (int i = 0; i < 3; i++) expect_xfer(64'h1111_2222_3333_4444 * (i + 1), 3, 1'b0);
      send_cmd(2'b11, 3'd7);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check_eq("abort_outputs", 64'({dq_oe, dqs_oe, dqs_rise, dm_rise, dm_fall, busy, done, underrun, dq_rise, dq_fall}), 64'd0);
      check_eq("abort_readies", 64'({wr_ready, cmd_ready}), 64'b11);
      check_eq("beats_before_rst", 64'(exp_q.size()), 64'd3);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("release_state", 64'({cmd_ready, wr_ready, busy, underrun}), 64'b1100);

      // FIFO must be empty after reset: only the new word may appear.
      push_word(64'h77);
      expect_xfer(64'h77, 0, 1'b0);
      send_cmd(2'b00, 3'd0);
      wait_done(3);

      check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
